receiver: RTL and testbench
===========================

# receiver

Serial frame receiver directly downstream of the team's 7-bit serial transmitter. Samples the one-bit-per-clock line, reassembles start/data/parity/stop frames and checks parity and framing. Presents each received word on a valid/ready output register to the consuming logic. Runs on the transmitter's clock, so no oversampling or line synchronizer.

## Interface
- `DATA_BITS`, default 7: payload width; frame length = DATA_BITS + 3 bit-times.
- `clk` in 1: rising-edge clock, one line bit per cycle.
- `rstn` in 1: asynchronous, active-low reset.
- `serial_in` in 1: serial line; idle high.
- `data_out` out DATA_BITS: received payload, D0 = first data bit after start.
- `valid` out 1: `data_out`/flags hold an unconsumed word.
- `ready` in 1: consumer accepts the word when `valid && ready` at a clock edge.
- `parity_err` out 1: parity mismatch on held word, qualified by `valid`.
- `frame_err` out 1: stop bit sampled 0 on held word, qualified by `valid`.
- `overrun` out 1: one-cycle pulse, completed frame discarded because holding register was full.

## Operation
- Frame on line, one bit per cycle: start (0), D0..D(DATA_BITS-1) LSB first, parity, stop (1). Back-to-back frames allowed: next start bit may follow the stop bit immediately.
- Parity is odd: D bits plus parity bit contain an odd number of ones. Expected parity = ~^data.
- FSM states: RECOVER, IDLE, DATA, PARITY, STOP.
  - RECOVER: wait for `serial_in`=1, then go to IDLE. Reset state.
  - IDLE: `serial_in`=0 sampled -> DATA, bit counter = 0.
  - DATA: shift sampled bit into position counter; after bit DATA_BITS-1 -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: complete frame. If stop=1 -> IDLE; if stop=0 -> RECOVER. The low line must not be taken as a new start bit.
- Completion at the STOP edge:
  - If holding register free (`valid`=0), or being consumed at the same edge (`valid && ready`): load `data_out`, `parity_err`, `frame_err`; `valid` = 1.
  - Otherwise keep the old word unchanged, drop the new frame, and pulse `overrun` high for one cycle.
- `valid && ready` with no completion at the same edge: `valid` -> 0; `data_out`/flags keep their value.
- `ready` while `valid`=0 is ignored.
- Frames with errors are still delivered, with their flags set.
- Bit counter width = clog2(DATA_BITS); no wrap beyond DATA_BITS-1.

## Timing
- Reset (async, any state, mid-frame included): state = RECOVER, counter = 0, `data_out` = 0, `valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun` = 0. A partial frame is discarded.
- Let S be the edge that samples the start bit:
  - D0..D(DATA_BITS-1) sampled at S+1..S+DATA_BITS.
  - Parity sampled at S+DATA_BITS+1; stop sampled at S+DATA_BITS+2.
  - `valid` high in the cycle after S+DATA_BITS+2. With DATA_BITS=7: S+9.
- Against the transmitter: `start` sampled at edge T gives S = T+1, so `valid` rises after edge T+10.
- All outputs registered; no combinational path from `serial_in` or `ready` to any output.
- Minimum line restart: IDLE one cycle after a good stop; first start detectable at the next edge.

## Configuration
- `RX_PARITY_CHECK_EN` defined: parity compared as above and `parity_err` reflects the result.
- Not defined: parity bit still consumed as one bit-time, but never checked, and `parity_err` is constant 0. Frame timing is identical in both builds.

## Test plan
- Single frame, data 7'h55 (line 0,1,0,1,0,1,0,1,1,1), `ready`=0 -> after S+9: `valid`=1, `data_out`=7'h55, `parity_err`=0, `frame_err`=0; held until `ready`=1, then `valid`=0 next cycle.
- Parity error (macro on): data 7'h7F sent with parity 1 -> `data_out`=7'h7F, `parity_err`=1. Macro off: same stimulus gives `parity_err`=0.
- Framing error: data 7'h00, parity 1, stop 0, line held 0 for 3 more cycles then 1 -> `frame_err`=1, and no new frame starts until the line returns high.
- Back-to-back: 7'h01 then 7'h7E with no idle gap, `ready` tied 1 -> two `valid` cycles 10 cycles apart, correct data each, no `overrun`.
- Overrun: two frames, `ready`=0 -> first word kept, `overrun` high for exactly one cycle at the second STOP edge; simultaneous `ready`=1 at that edge instead loads the second word with no `overrun`.
- Reset mid-frame: `rstn` low at S+4 for 1 cycle, line returns to 1, then a clean 7'h2A frame -> outputs all 0 during reset, then 7'h2A received correctly.

Source files
------------

// File: rtl/receiver.sv
// Serial frame receiver: start / DATA_BITS data (LSB first) / odd parity / stop, one bit per clock.
// Optional parity checking is enabled by defining RX_PARITY_CHECK_EN.
module receiver #(
    parameter int DATA_BITS = 7
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

    localparam logic [2:0] ST_RECOVER = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;

    logic [2:0]           state_r, state_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r, perr_r, ferr_r, ovr_r;
    logic                 complete_s, accept_s, perr_s;

`ifdef RX_PARITY_CHECK_EN
    logic par_r;

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~^d;
    endfunction
`endif

    // Frame sequencing and bit counter
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_RECOVER: begin
                if (serial_in) state_s = ST_IDLE;
                else           state_s = ST_RECOVER;
            end
            ST_IDLE: begin
                if (!serial_in) begin
                    state_s = ST_DATA;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt_r == LAST_BIT) state_s = ST_PARITY;
                else                   cnt_s   = cnt_r + 1'b1;
            end
            ST_PARITY: state_s = ST_STOP;
            // A low stop bit means the line is stuck low: wait for it to rise before hunting starts
            ST_STOP: begin
                if (serial_in) state_s = ST_IDLE;
                else           state_s = ST_RECOVER;
            end
            default: state_s = ST_RECOVER;
        endcase
    end

    // Completion handshake against the holding register
    always_comb begin
        complete_s = (state_r == ST_STOP);
        accept_s   = complete_s && (!valid_r || ready);
`ifdef RX_PARITY_CHECK_EN
        perr_s     = (odd_parity(shift_r) != par_r);
`else
        perr_s     = 1'b0;
`endif
    end

    // State, shift register and output holding register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_RECOVER;
            cnt_r   <= '0;
            shift_r <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (state_r == ST_DATA) shift_r[cnt_r] <= serial_in;
`ifdef RX_PARITY_CHECK_EN
            if (state_r == ST_PARITY) par_r <= serial_in;
`endif
            if (accept_s) begin
                data_r  <= shift_r;
                perr_r  <= perr_s;
                ferr_r  <= ~serial_in;
                valid_r <= 1'b1;
            end else if (valid_r && ready) begin
                valid_r <= 1'b0;
            end
            ovr_r <= complete_s && !accept_s;
        end
    end

    assign data_out   = data_r;
    assign valid      = valid_r;
    assign parity_err = perr_r;
    assign frame_err  = ferr_r;
    assign overrun    = ovr_r;

endmodule

// File: tb/tb_receiver.sv
// Self-checking bench for receiver: table of frames plus hand-written corner sequences.
module tb_receiver;

    localparam int DB = 7;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          serial_in = 1'b1;
    logic          ready = 1'b0;
    logic [DB-1:0] data_out;
    logic          valid, parity_err, frame_err, overrun;

    receiver #(.DATA_BITS(DB)) dut (
        .clk(clk), .rstn(rstn), .serial_in(serial_in), .data_out(data_out),
        .valid(valid), .ready(ready), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    typedef struct {
        logic [DB-1:0] data;
        logic          par;
        logic          stop;
        int            gap;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   ovr_cnt = 0;
    int   ovr_before;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[8];

`ifdef RX_PARITY_CHECK_EN
    localparam logic PERR_ON_BAD = 1'b1;
`else
    localparam logic PERR_ON_BAD = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_perr(input logic [DB-1:0] d, input logic p);
`ifdef RX_PARITY_CHECK_EN
        return p != ~^d;
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard: a word is consumed at the next rising edge whenever valid && ready here
    always @(negedge clk) begin
        if (rstn) begin
            if (overrun) ovr_cnt++;
            if (valid && ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_data", 32'(data_out), 32'(mon_e.data));
                    check("sb_parity_err", 32'(parity_err), 32'(mon_e.perr));
                    check("sb_frame_err", 32'(frame_err), 32'(mon_e.ferr));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        step();
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic s,
                              input bit push, input bit rdy_stop, input bit chk_t);
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        send_bit(p);
        if (chk_t) check("valid_before_stop", 32'(valid), 32'd0);
        if (rdy_stop) ready = 1'b1;
        if (push) sb_q.push_back('{data: d, perr: exp_perr(d, p), ferr: ~s});
        send_bit(s);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_data"}, 32'(data_out), 32'd0);
        check({tag, "_perr"}, 32'(parity_err), 32'd0);
        check({tag, "_ferr"}, 32'(frame_err), 32'd0);
        check({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{data: 7'h55, par: 1'b1, stop: 1'b1, gap: 0};
        vecs[1] = '{data: 7'h01, par: 1'b0, stop: 1'b1, gap: 0};
        vecs[2] = '{data: 7'h7E, par: 1'b1, stop: 1'b1, gap: 0};
        vecs[3] = '{data: 7'h7F, par: 1'b1, stop: 1'b1, gap: 0};
        vecs[4] = '{data: 7'h00, par: 1'b1, stop: 1'b1, gap: 0};
        vecs[5] = '{data: 7'h00, par: 1'b1, stop: 1'b0, gap: 1};
        vecs[6] = '{data: 7'h2A, par: 1'b0, stop: 1'b1, gap: 2};
        vecs[7] = '{data: 7'h13, par: 1'b1, stop: 1'b1, gap: 1};

        repeat (3) step();
        check_zero("reset");
        rstn = 1'b1;
        repeat (2) send_bit(1'b1);

        // Single frame held until consumed, with latency check
        send_frame(7'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("t1_valid", 32'(valid), 32'd1);
        check("t1_data", 32'(data_out), 32'h55);
        check("t1_perr", 32'(parity_err), 32'd0);
        check("t1_ferr", 32'(frame_err), 32'd0);
        repeat (3) send_bit(1'b1);
        check("t1_hold", 32'(valid), 32'd1);
        ready = 1'b1;
        step();
        check("t1_released", 32'(valid), 32'd0);
        ready = 1'b0;
        send_bit(1'b1);

        // Parity error
        send_frame(7'h7F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("par_data", 32'(data_out), 32'h7F);
        check("par_perr", 32'(parity_err), 32'(PERR_ON_BAD));
        ready = 1'b1;
        step();
        ready = 1'b0;

        // Framing error: line stuck low must not look like a start bit
        send_frame(7'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("fe_valid", 32'(valid), 32'd1);
        check("fe_ferr", 32'(frame_err), 32'd1);
        ovr_before = ovr_cnt;
        repeat (3) send_bit(1'b0);
        repeat (12) send_bit(1'b1);
        check("fe_no_restart", 32'(ovr_cnt), 32'(ovr_before));
        ready = 1'b1;
        step();
        ready = 1'b0;

        // Overrun: second frame dropped while first is held
        send_frame(7'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(7'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_kept", 32'(data_out), 32'h11);
        send_bit(1'b1);
        check("ovr_one_cycle", 32'(overrun), 32'd0);
        ready = 1'b1;
        step();
        ready = 1'b0;

        // Consume at the same edge as the second completion: no overrun
        send_frame(7'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(7'h44, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("swap_data", 32'(data_out), 32'h44);
        check("swap_valid", 32'(valid), 32'd1);
        check("swap_no_ovr", 32'(overrun), 32'd0);
        send_bit(1'b1);
        ready = 1'b0;

        // Table of back-to-back frames, consumer always ready
        ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, 1'b1, 1'b0, 1'b0);
            for (int g = 0; g < vecs[v].gap; g++) send_bit(1'b1);
        end
        repeat (3) send_bit(1'b1);
        ready = 1'b0;

        // Reset in the middle of a frame while a word is held
        send_frame(7'h6C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rstn = 1'b0;
        #1;
        check_zero("midrst");
        step();
        rstn = 1'b1;
        repeat (2) send_bit(1'b1);
        ready = 1'b1;
        send_frame(7'h2A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) send_bit(1'b1);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("ovr_total", 32'(ovr_cnt), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
